// File: rtl/ps2_dir_pkg.sv
// ps2_dir_pkg
//   Shared definitions for the PS/2 direction decoder slice: prefix and
//   scan-code constants, direction and parser-state encodings, the 3-bit
//   event word layout {release, dir}, and the scan-code mapping function.
package ps2_dir_pkg;

    localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

    localparam logic [7:0] SC_KEY_W = 8'h1D;
    localparam logic [7:0] SC_KEY_S = 8'h1B;
    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_D = 8'h23;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

    // Event word as stored in the FIFO: MSB = release flag, LSBs = direction.
    typedef struct packed {
        logic rel;
        dir_e dir;
    } event_t;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } map_t;

    localparam int EVENT_W = $bits(event_t);

    // Translate a scan code into a direction. Arrows only exist behind the
    // E0 prefix; WASD only as unprefixed codes and only when enabled.
    function automatic map_t map_code(input logic [7:0] code,
                                      input logic       ext,
                                      input logic       wasd_en);
        map_t m;
        m.hit = 1'b0;
        m.dir = DIR_UP;
        if (ext) begin
            case (code)
                SC_ARROW_UP:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
                SC_ARROW_DOWN:  begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
                SC_ARROW_LEFT:  begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
                SC_ARROW_RIGHT: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
                default:        begin m.hit = 1'b0; m.dir = DIR_UP;    end
            endcase
        end else if (wasd_en) begin
            case (code)
                SC_KEY_W: begin m.hit = 1'b1; m.dir = DIR_UP;    end
                SC_KEY_S: begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
                SC_KEY_A: begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
                SC_KEY_D: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
                default:  begin m.hit = 1'b0; m.dir = DIR_UP;    end
            endcase
        end else begin
            m.hit = 1'b0;
            m.dir = DIR_UP;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// ps2_direction_decoder_if
//   Bundles the byte-stream input and the event/status outputs of the
//   direction decoder.
//   master: drives EN, ps2_byte, ps2_byte_valid, rd_en; observes events.
//   slave : the decoder itself.
//   Signals: EN (decoder enable), ps2_byte/ps2_byte_valid (scan-code byte
//   and strobe), rd_en (pop event), event_valid/event_dir/event_release
//   (FIFO head), held (live key mask), fifo_count, overflow (sticky drop).
interface ps2_direction_decoder_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
    logic             EN;
    logic [7:0]       ps2_byte;
    logic             ps2_byte_valid;
    logic             rd_en;
    logic             event_valid;
    logic [1:0]       event_dir;
    logic             event_release;
    logic [3:0]       held;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output EN, ps2_byte, ps2_byte_valid, rd_en,
        input  event_valid, event_dir, event_release, held, fifo_count, overflow
    );

    modport slave (
        input  EN, ps2_byte, ps2_byte_valid, rd_en,
        output event_valid, event_dir, event_release, held, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
//   Synchronous show-ahead FIFO. The head word, its valid flag and the
//   occupancy count are registered so a push in cycle N is visible in N+1.
//   Ports: clk, rst_n (synchronous active-low), push/push_data (write),
//   pop_req (read, ignored when empty), head_valid/head_data (show-ahead
//   head, data forced to 0 when empty), count (entries stored),
//   dropped (combinational: this cycle's push is being discarded).
//   A push while full succeeds only if a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             dropped
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             head_valid_r;
    logic [WIDTH-1:0] head_r;

    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    // Next pointers, count and head word for the registered show-ahead view.
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        full_s    = (count_r == CNT_FULL);
        pop_s     = pop_req && !empty_s;
        push_ok_s = push && (!full_s || pop_s);

        wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s     ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // The slot being written this cycle becomes the head only when it is
        // the next read slot (FIFO empty, or one entry popped and replaced).
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            head_nxt_s = {WIDTH{1'b0}};
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers and registered head/count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_valid_r <= 1'b0;
            head_r       <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            head_r       <= head_nxt_s;
        end
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_r;
    assign count      = count_r;
    assign dropped    = push && !push_ok_s;

endmodule

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
//   Parses the raw PS/2 byte stream (E0 extended prefix, F0 break prefix)
//   and turns arrow keys (and optionally unprefixed WASD) into press/release
//   events for four directions, queued in a show-ahead event FIFO. Also
//   keeps a live mask of held directions.
//   Ports: CLOCK_50 (clock), KEY (synchronous active-low reset),
//   bus (ps2_direction_decoder_if.slave): EN, ps2_byte, ps2_byte_valid,
//   rd_en in; event_valid, event_dir, event_release, held, fifo_count,
//   overflow out.
//   Build option: define PS2_TYPEMATIC_FILTER_EN to suppress make codes for
//   a direction that is already held (keyboard auto-repeat).
module ps2_direction_decoder
    import ps2_dir_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ENABLE_WASD = 1,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   CLOCK_50,
    input  logic                   KEY,
    ps2_direction_decoder_if.slave bus
);
    localparam logic WASD_EN = (ENABLE_WASD != 32'sd0) ? 1'b1 : 1'b0;

    parse_state_e     state_r;
    parse_state_e     state_nxt_s;
    logic [3:0]       held_r;
    logic [3:0]       held_nxt_s;
    logic             overflow_r;

    logic             is_prefix_s;
    logic             ext_s;
    logic             brk_s;
    map_t             map_s;
    logic             push_s;
    event_t           push_evt_s;

    logic             fifo_valid_s;
    logic [EVENT_W-1:0] fifo_head_s;
    event_t           head_evt_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_dropped_s;

    // Parser state register.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Parser next state; a prefix byte in a break state abandons the sequence.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.EN) begin
            state_nxt_s = ST_IDLE;
        end else if (bus.ps2_byte_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.ps2_byte == SC_PREFIX_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else if (bus.ps2_byte == SC_PREFIX_BRK) begin
                        state_nxt_s = ST_BRK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (bus.ps2_byte == SC_PREFIX_BRK) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else if (bus.ps2_byte == SC_PREFIX_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK:     state_nxt_s = ST_IDLE;
                ST_EXT_BRK: state_nxt_s = ST_IDLE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Parser outputs: decoded event push and next held mask.
    always_comb begin
        is_prefix_s = (bus.ps2_byte == SC_PREFIX_EXT) || (bus.ps2_byte == SC_PREFIX_BRK);
        ext_s       = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
        brk_s       = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
        map_s       = map_code(bus.ps2_byte, ext_s, WASD_EN);
        push_s      = 1'b0;
        push_evt_s  = '{rel: 1'b0, dir: DIR_UP};
        held_nxt_s  = held_r;

        if (!bus.EN) begin
            held_nxt_s = 4'b0000;
        end else if (bus.ps2_byte_valid && !is_prefix_s && map_s.hit) begin
            if (brk_s) begin
                held_nxt_s[map_s.dir] = 1'b0;
                push_s                = 1'b1;
                push_evt_s            = '{rel: 1'b1, dir: map_s.dir};
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                // Auto-repeat of an already held direction is swallowed.
                if (held_r[map_s.dir]) begin
                    push_s = 1'b0;
                end else begin
                    held_nxt_s[map_s.dir] = 1'b1;
                    push_s                = 1'b1;
                    push_evt_s            = '{rel: 1'b0, dir: map_s.dir};
                end
`else
                held_nxt_s[map_s.dir] = 1'b1;
                push_s                = 1'b1;
                push_evt_s            = '{rel: 1'b0, dir: map_s.dir};
`endif
            end
        end else begin
            held_nxt_s = held_r;
        end
    end

    // Held mask and sticky overflow flag.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            held_r     <= 4'b0000;
            overflow_r <= 1'b0;
        end else begin
            held_r     <= held_nxt_s;
            overflow_r <= overflow_r | fifo_dropped_s;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (CLOCK_50),
        .rst_n      (KEY),
        .push       (push_s),
        .push_data  (push_evt_s),
        .pop_req    (bus.rd_en),
        .head_valid (fifo_valid_s),
        .head_data  (fifo_head_s),
        .count      (fifo_count_s),
        .dropped    (fifo_dropped_s)
    );

    assign head_evt_s        = event_t'(fifo_head_s);
    assign bus.event_valid   = fifo_valid_s;
    assign bus.event_dir     = head_evt_s.dir;
    assign bus.event_release = head_evt_s.rel;
    assign bus.held          = held_r;
    assign bus.fifo_count    = fifo_count_s;
    assign bus.overflow      = overflow_r;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Testbench for ps2_direction_decoder: directed scenarios plus randomized
// byte streams checked against a queue-based behavioural model.
module tb_ps2_direction_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       key = 1'b0;
    logic       en = 1'b1;
    logic       byte_v = 1'b0;
    logic [7:0] byte_d = 8'h00;
    logic       rd = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [2:0] mq[$];
    logic [3:0] m_held = 4'b0000;
    logic       m_ovf  = 1'b0;
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;

    always #10 clk = ~clk;

    ps2_direction_decoder_if #(.FIFO_DEPTH(DEPTH)) u_if ();
    ps2_direction_decoder_if #(.FIFO_DEPTH(DEPTH)) u_if_nw ();

    assign u_if.EN                = en;
    assign u_if.ps2_byte          = byte_d;
    assign u_if.ps2_byte_valid    = byte_v;
    assign u_if.rd_en             = rd;
    assign u_if_nw.EN             = en;
    assign u_if_nw.ps2_byte       = byte_d;
    assign u_if_nw.ps2_byte_valid = byte_v;
    assign u_if_nw.rd_en          = rd;

    ps2_direction_decoder #(.FIFO_DEPTH(DEPTH), .ENABLE_WASD(1)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .bus      (u_if)
    );

    ps2_direction_decoder #(.FIFO_DEPTH(DEPTH), .ENABLE_WASD(0)) dut_nw (
        .CLOCK_50 (clk),
        .KEY      (key),
        .bus      (u_if_nw)
    );

    task automatic model_push(input logic [2:0] ev);
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1'b1;
    endtask

    // One clock edge of the reference behaviour (WASD enabled).
    task automatic model_cycle(input logic v, input logic [7:0] b, input logic e,
                               input logic r, input logic k);
        logic       hit;
        logic [1:0] d;
        if (!k) begin
            mq.delete();
            m_held = 4'b0000; m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (!e) begin
                m_ext = 1'b0; m_brk = 1'b0; m_held = 4'b0000;
            end else if (v) begin
                if (b == 8'hE0) begin
                    if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
                    else m_ext = 1'b1;
                end else if (b == 8'hF0) begin
                    if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
                    else m_brk = 1'b1;
                end else begin
                    hit = 1'b0; d = 2'd0;
                    if (m_ext) begin
                        case (b)
                            8'h75: begin hit = 1'b1; d = 2'd0; end
                            8'h72: begin hit = 1'b1; d = 2'd1; end
                            8'h6B: begin hit = 1'b1; d = 2'd2; end
                            8'h74: begin hit = 1'b1; d = 2'd3; end
                            default: hit = 1'b0;
                        endcase
                    end else begin
                        case (b)
                            8'h1D: begin hit = 1'b1; d = 2'd0; end
                            8'h1B: begin hit = 1'b1; d = 2'd1; end
                            8'h1C: begin hit = 1'b1; d = 2'd2; end
                            8'h23: begin hit = 1'b1; d = 2'd3; end
                            default: hit = 1'b0;
                        endcase
                    end
                    if (hit) begin
                        if (m_brk) begin
                            m_held[d] = 1'b0;
                            model_push({1'b1, d});
                        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                            if (!m_held[d]) begin
                                m_held[d] = 1'b1;
                                model_push({1'b0, d});
                            end
`else
                            m_held[d] = 1'b1;
                            model_push({1'b0, d});
`endif
                        end
                    end
                    m_ext = 1'b0; m_brk = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus; outputs are settled 1 time unit after the edge.
    task automatic tick(input logic v, input logic [7:0] b, input logic r);
        @(negedge clk);
        byte_v = v; byte_d = b; rd = r;
        model_cycle(v, b, en, r, key);
        @(posedge clk);
        #1;
        byte_v = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        key = 1'b0; en = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        key = 1'b1;
        n_checks++; if (u_if.event_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", u_if.event_valid); end
        n_checks++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", u_if.fifo_count); end
        n_checks++; if (u_if.held !== 4'b0000) begin n_fail++; $display("FAIL rst_held got=%b exp=0000", u_if.held); end
        n_checks++; if (u_if.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%0b exp=0", u_if.overflow); end
    endtask

    task automatic test_press_release();
        tick(1'b1, 8'hE0, 1'b0);
        tick(1'b1, 8'h75, 1'b0);
        n_checks++; if (u_if.event_valid !== 1'b1) begin n_fail++; $display("FAIL pr_valid got=%0b exp=1", u_if.event_valid); end
        n_checks++; if ({u_if.event_release, u_if.event_dir} !== 3'b000) begin n_fail++; $display("FAIL pr_head got=%b exp=000", {u_if.event_release, u_if.event_dir}); end
        n_checks++; if (u_if.held !== 4'b0001) begin n_fail++; $display("FAIL pr_held got=%b exp=0001", u_if.held); end
        n_checks++; if (u_if.fifo_count !== 3'd1) begin n_fail++; $display("FAIL pr_count got=%0d exp=1", u_if.fifo_count); end
        tick(1'b1, 8'hE0, 1'b0);
        tick(1'b1, 8'hF0, 1'b0);
        tick(1'b1, 8'h75, 1'b0);
        n_checks++; if (u_if.fifo_count !== 3'd2) begin n_fail++; $display("FAIL rel_count got=%0d exp=2", u_if.fifo_count); end
        n_checks++; if (u_if.held !== 4'b0000) begin n_fail++; $display("FAIL rel_held got=%b exp=0000", u_if.held); end
        n_checks++; if ({u_if.event_release, u_if.event_dir} !== 3'b000) begin n_fail++; $display("FAIL rel_head got=%b exp=000", {u_if.event_release, u_if.event_dir}); end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++; if ({u_if.event_valid, u_if.event_release, u_if.event_dir} !== 4'b1100) begin n_fail++; $display("FAIL pop1_head got=%b exp=1100", {u_if.event_valid, u_if.event_release, u_if.event_dir}); end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++; if ({u_if.event_valid, u_if.event_release, u_if.event_dir} !== 4'b0000) begin n_fail++; $display("FAIL pop2_empty got=%b exp=0000", {u_if.event_valid, u_if.event_release, u_if.event_dir}); end
    endtask

    task automatic test_wasd();
        logic [2:0] nw_cnt;
        logic [3:0] nw_held;
        nw_cnt = u_if_nw.fifo_count; nw_held = u_if_nw.held;
        tick(1'b1, 8'h1D, 1'b0);
        n_checks++; if ({u_if.fifo_count, u_if.event_release, u_if.event_dir} !== 6'b001_000) begin n_fail++; $display("FAIL wasd_press got=%b exp=001000", {u_if.fifo_count, u_if.event_release, u_if.event_dir}); end
        n_checks++; if (u_if.held !== 4'b0001) begin n_fail++; $display("FAIL wasd_held got=%b exp=0001", u_if.held); end
        n_checks++; if (u_if_nw.fifo_count !== nw_cnt) begin n_fail++; $display("FAIL nowasd_count got=%0d exp=%0d", u_if_nw.fifo_count, nw_cnt); end
        n_checks++; if (u_if_nw.held !== nw_held) begin n_fail++; $display("FAIL nowasd_held got=%b exp=%b", u_if_nw.held, nw_held); end
        tick(1'b1, 8'hF0, 1'b0);
        tick(1'b1, 8'h1D, 1'b0);
        n_checks++; if (u_if.held !== 4'b0000) begin n_fail++; $display("FAIL wasd_rel_held got=%b exp=0000", u_if.held); end
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_overflow();
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h75, 1'b0);
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'hF0, 1'b0); tick(1'b1, 8'h75, 1'b0);
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h72, 1'b0);
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'hF0, 1'b0); tick(1'b1, 8'h72, 1'b0);
        n_checks++; if ({u_if.fifo_count, u_if.overflow} !== 4'b100_0) begin n_fail++; $display("FAIL full_noovf got=%b exp=1000", {u_if.fifo_count, u_if.overflow}); end
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h6B, 1'b0);
        n_checks++; if (u_if.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", u_if.fifo_count); end
        n_checks++; if (u_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", u_if.overflow); end
        n_checks++; if ({u_if.event_release, u_if.event_dir} !== 3'b000) begin n_fail++; $display("FAIL ovf_head got=%b exp=000", {u_if.event_release, u_if.event_dir}); end
        n_checks++; if (u_if.held !== 4'b0100) begin n_fail++; $display("FAIL ovf_held got=%b exp=0100", u_if.held); end
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'hF0, 1'b0); tick(1'b1, 8'h6B, 1'b1);
        n_checks++; if ({u_if.fifo_count, u_if.overflow} !== 4'b100_1) begin n_fail++; $display("FAIL fullpp_count got=%b exp=1001", {u_if.fifo_count, u_if.overflow}); end
        n_checks++; if ({u_if.event_release, u_if.event_dir} !== 3'b100) begin n_fail++; $display("FAIL fullpp_head got=%b exp=100", {u_if.event_release, u_if.event_dir}); end
        n_checks++; if (mq.size() != 4 || mq[3] !== 3'b110) begin n_fail++; $display("FAIL fullpp_model got=%0d exp=4", mq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({u_if.event_release, u_if.event_dir} !== mq[0]) begin n_fail++; $display("FAIL drain_head got=%b exp=%b", {u_if.event_release, u_if.event_dir}, mq[0]); end
            tick(1'b0, 8'h00, 1'b1);
        end
        n_checks++; if ({u_if.event_valid, u_if.overflow} !== 2'b01) begin n_fail++; $display("FAIL drain_end got=%b exp=01", {u_if.event_valid, u_if.overflow}); end
        key = 1'b0; tick(1'b0, 8'h00, 1'b0); key = 1'b1;
        n_checks++; if (u_if.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%0b exp=0", u_if.overflow); end
    endtask

    task automatic test_typematic();
        logic [2:0] exp_cnt;
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_cnt = 3'd1;
`else
        exp_cnt = 3'd2;
`endif
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h6B, 1'b0);
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h6B, 1'b0);
        n_checks++; if (u_if.fifo_count !== exp_cnt) begin n_fail++; $display("FAIL typematic_count got=%0d exp=%0d", u_if.fifo_count, exp_cnt); end
        n_checks++; if (u_if.held !== 4'b0100) begin n_fail++; $display("FAIL typematic_held got=%b exp=0100", u_if.held); end
        key = 1'b0; tick(1'b0, 8'h00, 1'b0); key = 1'b1;
    endtask

    task automatic test_reset_mid_and_en();
        tick(1'b1, 8'hE0, 1'b0);
        key = 1'b0; tick(1'b0, 8'h00, 1'b0); key = 1'b1;
        tick(1'b1, 8'h74, 1'b0);
        n_checks++; if ({u_if.event_valid, u_if.fifo_count, u_if.held} !== 8'b0_000_0000) begin n_fail++; $display("FAIL rstmid got=%b exp=00000000", {u_if.event_valid, u_if.fifo_count, u_if.held}); end
        en = 1'b0;
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h74, 1'b0);
        n_checks++; if ({u_if.event_valid, u_if.fifo_count, u_if.held} !== 8'b0_000_0000) begin n_fail++; $display("FAIL en_off got=%b exp=00000000", {u_if.event_valid, u_if.fifo_count, u_if.held}); end
        en = 1'b1; tick(1'b1, 8'hE0, 1'b0);
        en = 1'b0; tick(1'b0, 8'h00, 1'b0);
        en = 1'b1; tick(1'b1, 8'h74, 1'b0);
        n_checks++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL en_fall_mid got=%0d exp=0", u_if.fifo_count); end
        tick(1'b1, 8'hE0, 1'b0); tick(1'b1, 8'h74, 1'b0);
        en = 1'b0; tick(1'b0, 8'h00, 1'b0);
        n_checks++; if ({u_if.event_valid, u_if.event_release, u_if.event_dir, u_if.fifo_count} !== 7'b1_011_001) begin n_fail++; $display("FAIL en_off_fifo got=%b exp=1011001", {u_if.event_valid, u_if.event_release, u_if.event_dir, u_if.fifo_count}); end
        n_checks++; if (u_if.held !== 4'b0000) begin n_fail++; $display("FAIL en_off_held got=%b exp=0000", u_if.held); end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL en_off_pop got=%0d exp=0", u_if.fifo_count); end
        en = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] pool [12];
        logic [7:0] b;
        logic [2:0] exp_head;
        pool = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int c = 0; c < 600; c++) begin
            key = ($urandom_range(0, 99) != 0);
            en  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 11)];
            tick(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) == 0));
            exp_head = (mq.size() > 0) ? mq[0] : 3'b000;
            n_checks++; if (u_if.event_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, u_if.event_valid, (mq.size() > 0)); end
            n_checks++; if ({u_if.event_release, u_if.event_dir} !== exp_head) begin n_fail++; $display("FAIL rnd_head c=%0d got=%b exp=%b", c, {u_if.event_release, u_if.event_dir}, exp_head); end
            n_checks++; if (u_if.fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, u_if.fifo_count, mq.size()); end
            n_checks++; if (u_if.held !== m_held) begin n_fail++; $display("FAIL rnd_held c=%0d got=%b exp=%b", c, u_if.held, m_held); end
            n_checks++; if (u_if.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, u_if.overflow, m_ovf); end
        end
        key = 1'b1; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_wasd();
        test_overflow();
        test_typematic();
        test_reset_mid_and_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
